// File: rtl/ip_ttl_decr_stream.sv
// ip_ttl_decr_stream: streaming IPv4 TTL decrement with incremental header
// checksum update (HC' = ~(~HC + ~m + m')), one registered stage, 32-bit
// big-endian sop/eop/valid/ready words.
// Handshake: a word moves on valid & ready; inReady never waits on outReady
// except through the output register (inReady = ~outValid | outReady).
// Optional build macro IP_TTL_EXPIRE_DROP_EN: buffer the header words until
// the TTL word is seen and silently drop expired packets.
module ip_ttl_decr_stream #(
    parameter int HDR_WORD_OFS = 0,
    parameter int MIN_TTL      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inData,
    input  logic        inSop,
    input  logic        inEop,
    input  logic        inValid,
    output logic        inReady,
    output logic [31:0] outData,
    output logic        outSop,
    output logic        outEop,
    output logic        outValid,
    input  logic        outReady,
    output logic        outExpired,
    output logic [31:0] pktCnt,
    output logic [15:0] expCnt
);
    localparam int            IW        = $clog2(HDR_WORD_OFS + 4);
    localparam logic [IW-1:0] IDX_HDR   = IW'(HDR_WORD_OFS);
    localparam logic [IW-1:0] IDX_TTL   = IW'(HDR_WORD_OFS + 2);
    localparam logic [IW-1:0] IDX_MAX   = IW'(HDR_WORD_OFS + 3);
    localparam logic [7:0]    MIN_TTL_B = 8'(MIN_TTL);

    logic [IW-1:0] idx_q, idx_d, cur_idx;
    logic          in_pkt_q, in_pkt_d;
    logic          is_v4_q, is_v4_d;
    logic [31:0]   pkt_cnt_q, pkt_cnt_d;
    logic [15:0]   exp_cnt_q, exp_cnt_d;
    logic [31:0]   out_data_q, out_data_d;
    logic          out_sop_q, out_sop_d, out_eop_q, out_eop_d;
    logic          out_valid_q, out_valid_d;
    logic          take, out_free, active, hdr_v4, at_ttl, ttl_exp, patch;
    logic [7:0]    ttl_m1;
    logic [17:0]   sum18;
    logic [16:0]   fold17;
    logic [15:0]   fold16;
    logic [31:0]   fwd_data;

    assign out_free = ~out_valid_q | outReady;
    assign take     = inValid & inReady;
    // A sop word always restarts the header index; words before any sop are orphans.
    assign cur_idx  = inSop ? '0 : idx_q;
    assign active   = inSop | in_pkt_q;
    assign hdr_v4   = (inData[31:28] == 4'd4) && (inData[27:24] >= 4'd5);
    assign at_ttl   = active && !inSop && is_v4_q && (cur_idx == IDX_TTL);
    assign ttl_exp  = at_ttl && (inData[31:24] <= MIN_TTL_B);
    assign patch    = at_ttl && !ttl_exp;
    assign ttl_m1   = inData[31:24] - 8'd1;

    // Incremental checksum: 18-bit sum, fold to 17, fold to 16, invert.
    always_comb begin
        sum18    = {2'b00, ~inData[15:0]} + {2'b00, ~inData[31:16]} + {2'b00, ttl_m1, inData[23:16]};
        fold17   = {1'b0, sum18[15:0]} + {15'd0, sum18[17:16]};
        fold16   = fold17[15:0] + {15'd0, fold17[16]};
        fwd_data = patch ? {ttl_m1, inData[23:16], ~fold16} : inData;
    end

    // Header parsing state and saturating counters, advanced per accepted word.
    always_comb begin
        idx_d     = idx_q;
        in_pkt_d  = in_pkt_q;
        is_v4_d   = is_v4_q;
        pkt_cnt_d = pkt_cnt_q;
        exp_cnt_d = exp_cnt_q;
        if (take) begin
            idx_d    = (cur_idx == IDX_MAX) ? IDX_MAX : cur_idx + 1'b1;
            in_pkt_d = active & ~inEop;
            if (inSop) is_v4_d = 1'b0;
            if (active && (cur_idx == IDX_HDR)) begin
                is_v4_d = hdr_v4;
                if (hdr_v4 && (pkt_cnt_q != '1)) pkt_cnt_d = pkt_cnt_q + 32'd1;
            end
            if (ttl_exp && (exp_cnt_q != '1)) exp_cnt_d = exp_cnt_q + 16'd1;
        end
    end

    // Parse state, counters and the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            in_pkt_q    <= 1'b0;
            is_v4_q     <= 1'b0;
            pkt_cnt_q   <= '0;
            exp_cnt_q   <= '0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            in_pkt_q    <= in_pkt_d;
            is_v4_q     <= is_v4_d;
            pkt_cnt_q   <= pkt_cnt_d;
            exp_cnt_q   <= exp_cnt_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef IP_TTL_EXPIRE_DROP_EN
    localparam int BN = HDR_WORD_OFS + 2;
    localparam int BW = $clog2(BN + 1);
    localparam int PW = $clog2(BN);
    typedef enum logic [1:0] {ST_PASS, ST_HOLD, ST_DRAIN, ST_DROP} st_e;

    st_e           st_q, st_d;
    logic [33:0]   buf_q [BN];
    logic [33:0]   buf_d [BN];
    logic [BW-1:0] cnt_q, cnt_d;
    logic          hold_stop;

    // While holding, a new sop or a surviving TTL word is left waiting on the
    // input until the buffer has drained; an expired TTL word is swallowed.
    assign hold_stop  = inValid & (inSop | ((cur_idx == IDX_TTL) & ~ttl_exp));
    assign outExpired = 1'b0;

    // Ready depends on the hold/drain mode.
    always_comb begin
        case (st_q)
            ST_HOLD:  inReady = ~hold_stop;
            ST_DRAIN: inReady = 1'b0;
            default:  inReady = out_free;
        endcase
    end

    // Routing of words between hold buffer, output register and the bit bucket.
    always_comb begin
        st_d        = st_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_valid_d = out_valid_q & ~outReady;
        case (st_q)
            ST_DRAIN: begin
                if (out_free) begin
                    {out_sop_d, out_eop_d, out_data_d} = buf_q[0];
                    out_valid_d = 1'b1;
                    for (int i = 0; i < BN - 1; i++) buf_d[i] = buf_q[i+1];
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == BW'(1)) st_d = ST_PASS;
                end
            end
            ST_HOLD: begin
                if (take) begin
                    if (ttl_exp) begin
                        cnt_d = '0;
                        st_d  = inEop ? ST_PASS : ST_DROP;
                    end else begin
                        buf_d[cnt_q[PW-1:0]] = {inSop, inEop, inData};
                        cnt_d = cnt_q + 1'b1;
                        if (inEop) st_d = ST_DRAIN;
                    end
                end else if (hold_stop) begin
                    st_d = ST_DRAIN;
                end
            end
            default: begin
                if (take && inSop) begin
                    buf_d[0] = {inSop, inEop, inData};
                    cnt_d    = BW'(1);
                    st_d     = inEop ? ST_DRAIN : ST_HOLD;
                end else if (take && (st_q == ST_PASS)) begin
                    out_data_d  = fwd_data;
                    out_sop_d   = inSop;
                    out_eop_d   = inEop;
                    out_valid_d = 1'b1;
                end else if (take && inEop) begin
                    st_d = ST_PASS;
                end
            end
        endcase
    end

    // Hold/drop FSM state and hold buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= ST_PASS;
            cnt_q <= '0;
            for (int i = 0; i < BN; i++) buf_q[i] <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end
`else
    logic exp_flag_q, exp_flag_d, out_expired_q, out_expired_d, exp_next;

    assign inReady    = out_free;
    assign outExpired = out_expired_q;
    assign exp_next   = (inSop ? 1'b0 : exp_flag_q) | ttl_exp;

    // Every accepted word lands in the output register; the expired flag rides to eop.
    always_comb begin
        out_data_d    = out_data_q;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        out_expired_d = out_expired_q;
        exp_flag_d    = exp_flag_q;
        out_valid_d   = out_valid_q & ~outReady;
        if (take) begin
            out_data_d    = fwd_data;
            out_sop_d     = inSop;
            out_eop_d     = inEop;
            out_valid_d   = 1'b1;
            exp_flag_d    = exp_next;
            out_expired_d = exp_next & inEop;
        end
    end

    // Expired-packet flag and its eop-qualified output copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_flag_q    <= 1'b0;
            out_expired_q <= 1'b0;
        end else begin
            exp_flag_q    <= exp_flag_d;
            out_expired_q <= out_expired_d;
        end
    end
`endif

    assign outData  = out_data_q;
    assign outSop   = out_sop_q;
    assign outEop   = out_eop_q;
    assign outValid = out_valid_q;
    assign pktCnt   = pkt_cnt_q;
    assign expCnt   = exp_cnt_q;
endmodule
